// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags.
// Each register holds a committed value and the ROB id of its pending producer;
// tag 0 means the value is current. Commits retire tags and write values,
// renames install new tags, and a committed mispredict clears every tag.
module reg_rename_file #(
  parameter int unsigned REG_NUM   = 32,
  parameter int unsigned REG_POS_W = 5,
  parameter int unsigned ROB_ID_W  = 5,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [REG_POS_W-1:0] rs1_from_dsp,
  input  logic [REG_POS_W-1:0] rs2_from_dsp,
  output logic [DATA_W-1:0]    V1_to_dsp,
  output logic [ROB_ID_W-1:0]  Q1_to_dsp,
  output logic [DATA_W-1:0]    V2_to_dsp,
  output logic [ROB_ID_W-1:0]  Q2_to_dsp,
  input  logic                 ena_from_dsp,
  input  logic [REG_POS_W-1:0] rd_from_dsp,
  input  logic [ROB_ID_W-1:0]  rob_id_from_dsp,
  input  logic                 commit_flag,
  input  logic [REG_POS_W-1:0] rd_from_rob,
  input  logic [ROB_ID_W-1:0]  Q_from_rob,
  input  logic [DATA_W-1:0]    V_from_rob,
  input  logic                 commit_jump_flag
);

  logic [DATA_W-1:0]   v_q [REG_NUM];
  logic [DATA_W-1:0]   v_d [REG_NUM];
  logic [ROB_ID_W-1:0] q_q [REG_NUM];
  logic [ROB_ID_W-1:0] q_d [REG_NUM];

  // Operand read for rs1: current state, forwarding a commit that retires the tag seen.
  always_comb begin
    V1_to_dsp = '0;
    Q1_to_dsp = '0;
    if (rs1_from_dsp != '0) begin
      if (commit_flag && (rd_from_rob == rs1_from_dsp) && (q_q[rs1_from_dsp] == Q_from_rob)) begin
        V1_to_dsp = V_from_rob;
        Q1_to_dsp = '0;
      end else begin
        V1_to_dsp = v_q[rs1_from_dsp];
        Q1_to_dsp = q_q[rs1_from_dsp];
      end
    end
  end

  // Operand read for rs2: same rules as rs1.
  always_comb begin
    V2_to_dsp = '0;
    Q2_to_dsp = '0;
    if (rs2_from_dsp != '0) begin
      if (commit_flag && (rd_from_rob == rs2_from_dsp) && (q_q[rs2_from_dsp] == Q_from_rob)) begin
        V2_to_dsp = V_from_rob;
        Q2_to_dsp = '0;
      end else begin
        V2_to_dsp = v_q[rs2_from_dsp];
        Q2_to_dsp = q_q[rs2_from_dsp];
      end
    end
  end

  // Next state: commit first, then flush or rename, so a same-cycle rename overrides the tag clear.
  always_comb begin
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      v_d[i] = v_q[i];
      q_d[i] = q_q[i];
    end
    if (rdy) begin
      if (commit_flag && (rd_from_rob != '0)) begin
        v_d[rd_from_rob] = V_from_rob;
        if (q_q[rd_from_rob] == Q_from_rob) begin
          q_d[rd_from_rob] = '0;
        end
      end
      if (commit_jump_flag) begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
          q_d[i] = '0;
        end
      end else if (ena_from_dsp && (rd_from_dsp != '0)) begin
        q_d[rd_from_dsp] = rob_id_from_dsp;
      end
    end
    v_d[0] = '0;
    q_d[0] = '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        v_q[i] <= '0;
        q_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        v_q[i] <= v_d[i];
        q_q[i] <= q_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file: stimulus pushes expected operand reads,
// a negedge monitor pops and compares whenever a read is flagged.
module tb_reg_rename_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [4:0]  rs1_from_dsp, rs2_from_dsp;
  logic [31:0] V1_to_dsp, V2_to_dsp;
  logic [4:0]  Q1_to_dsp, Q2_to_dsp;
  logic        ena_from_dsp;
  logic [4:0]  rd_from_dsp, rob_id_from_dsp;
  logic        commit_flag;
  logic [4:0]  rd_from_rob, Q_from_rob;
  logic [31:0] V_from_rob;
  logic        commit_jump_flag;

  typedef struct {
    string       name;
    logic [31:0] v1;
    logic [4:0]  q1;
    logic [31:0] v2;
    logic [4:0]  q2;
  } exp_t;

  exp_t exp_q[$];
  logic chk;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  reg_rename_file #(
    .REG_NUM(32), .REG_POS_W(5), .ROB_ID_W(5), .DATA_W(32)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .rs1_from_dsp(rs1_from_dsp), .rs2_from_dsp(rs2_from_dsp),
    .V1_to_dsp(V1_to_dsp), .Q1_to_dsp(Q1_to_dsp),
    .V2_to_dsp(V2_to_dsp), .Q2_to_dsp(Q2_to_dsp),
    .ena_from_dsp(ena_from_dsp), .rd_from_dsp(rd_from_dsp),
    .rob_id_from_dsp(rob_id_from_dsp),
    .commit_flag(commit_flag), .rd_from_rob(rd_from_rob),
    .Q_from_rob(Q_from_rob), .V_from_rob(V_from_rob),
    .commit_jump_flag(commit_jump_flag)
  );

  // Monitor: compare the flagged read against the oldest expectation.
  always @(negedge clk) begin
    if (chk) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL no_expectation: read flagged with empty scoreboard");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (V1_to_dsp !== e.v1) begin
          n_bad++;
          $display("FAIL %s.V1: got %h want %h", e.name, V1_to_dsp, e.v1);
        end
        n_cmp++;
        if (Q1_to_dsp !== e.q1) begin
          n_bad++;
          $display("FAIL %s.Q1: got %0d want %0d", e.name, Q1_to_dsp, e.q1);
        end
        n_cmp++;
        if (V2_to_dsp !== e.v2) begin
          n_bad++;
          $display("FAIL %s.V2: got %h want %h", e.name, V2_to_dsp, e.v2);
        end
        n_cmp++;
        if (Q2_to_dsp !== e.q2) begin
          n_bad++;
          $display("FAIL %s.Q2: got %0d want %0d", e.name, Q2_to_dsp, e.q2);
        end
      end
    end
  end

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input string nm,
                    input logic [31:0] v1, input logic [4:0] q1,
                    input logic [31:0] v2, input logic [4:0] q2);
    exp_t e;
    rs1_from_dsp = a1;
    rs2_from_dsp = a2;
    e.name = nm; e.v1 = v1; e.q1 = q1; e.v2 = v2; e.q2 = q2;
    exp_q.push_back(e);
    chk = 1'b1;
  endtask

  task automatic ren(input logic [4:0] r, input logic [4:0] id);
    ena_from_dsp    = 1'b1;
    rd_from_dsp     = r;
    rob_id_from_dsp = id;
  endtask

  task automatic cmt(input logic [4:0] r, input logic [4:0] q, input logic [31:0] v);
    commit_flag = 1'b1;
    rd_from_rob = r;
    Q_from_rob  = q;
    V_from_rob  = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk              = 1'b0;
    ena_from_dsp     = 1'b0;
    commit_flag      = 1'b0;
    commit_jump_flag = 1'b0;
    rdy              = 1'b1;
    rst              = 1'b0;
    rs1_from_dsp     = '0;
    rs2_from_dsp     = '0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; chk = 1'b0;
    rs1_from_dsp = '0; rs2_from_dsp = '0;
    ena_from_dsp = 1'b0; rd_from_dsp = '0; rob_id_from_dsp = '0;
    commit_flag = 1'b0; rd_from_rob = '0; Q_from_rob = '0; V_from_rob = '0;
    commit_jump_flag = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    rd(5, 0, "reset", 32'h0, 0, 32'h0, 0); tick();

    ren(3, 4); rd(3, 0, "ren_sees_old", 32'h0, 0, 32'h0, 0); tick();
    rd(3, 0, "after_ren", 32'h0, 4, 32'h0, 0); tick();
    cmt(3, 4, 32'h55); rd(3, 0, "bypass", 32'h55, 0, 32'h0, 0); tick();
    rd(3, 0, "after_cmt", 32'h55, 0, 32'h0, 0); tick();

    ren(3, 4); tick();
    ren(3, 7); rd(3, 0, "ren2_old", 32'h55, 4, 32'h0, 0); tick();
    cmt(3, 4, 32'h9); rd(3, 0, "stale_cmt", 32'h55, 7, 32'h0, 0); tick();
    rd(3, 0, "young_tag", 32'h9, 7, 32'h0, 0); tick();

    ren(6, 2); tick();
    cmt(6, 2, 32'h10); ren(6, 3); rd(0, 6, "cmt_ren_same", 32'h0, 0, 32'h10, 0); tick();
    rd(0, 6, "ren_wins", 32'h0, 0, 32'h10, 3); tick();

    ren(1, 2); tick();
    ren(2, 5); tick();
    commit_jump_flag = 1'b1; cmt(1, 2, 32'h800); ren(4, 6);
    rd(1, 2, "flush_cyc", 32'h800, 0, 32'h0, 5); tick();
    rd(1, 4, "flush_x1_x4", 32'h800, 0, 32'h0, 0); tick();
    rd(2, 6, "flush_x2_x6", 32'h0, 0, 32'h10, 0); tick();
    rd(3, 0, "flush_x3", 32'h9, 0, 32'h0, 0); tick();

    cmt(0, 0, 32'hFF); ren(0, 3); rd(0, 0, "x0_cyc", 32'h0, 0, 32'h0, 0); tick();
    rd(0, 0, "x0_after", 32'h0, 0, 32'h0, 0); tick();

    rdy = 1'b0; ren(5, 9); cmt(1, 0, 32'h1234);
    rd(5, 0, "hold_cyc", 32'h0, 0, 32'h0, 0); tick();
    rd(1, 5, "hold_after", 32'h800, 0, 32'h0, 0); tick();

    ren(7, 31); tick();
    rd(7, 0, "tag31", 32'h0, 31, 32'h0, 0); tick();
    rst = 1'b1; cmt(9, 0, 32'hABCD); ren(8, 2); tick();
    rd(1, 7, "rst_clear", 32'h0, 0, 32'h0, 0); tick();
    rd(9, 8, "rst_prio", 32'h0, 0, 32'h0, 0); tick();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
